// File: rtl/out_bus_sequencer_pkg.sv
// Shared types for the out_bus sequencer: FSM states, source indices and the
// round-robin pick used to choose the next bus owner.
package out_bus_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BYTE0 = 3'd1,
    BYTE1 = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } seq_state_t;

  localparam int SRC_PC  = 0;
  localparam int SRC_MDR = 1;
  localparam int SRC_MAR = 2;

  localparam logic [2:0] SEL_PC  = 3'b001;
  localparam logic [2:0] SEL_MDR = 3'b010;
  localparam logic [2:0] SEL_MAR = 3'b100;

  // MAR as last owner makes PC the first choice after reset.
  localparam logic [2:0] LAST_RESET = SEL_MAR;

  // First requesting source strictly after 'last', wrapping PC->MDR->MAR->PC.
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [2:0] last);
    logic [2:0] pick;
    pick = 3'b000;
    case (last)
      SEL_PC: begin
        if (req[SRC_MDR])      pick = SEL_MDR;
        else if (req[SRC_MAR]) pick = SEL_MAR;
        else if (req[SRC_PC])  pick = SEL_PC;
      end
      SEL_MDR: begin
        if (req[SRC_MAR])      pick = SEL_MAR;
        else if (req[SRC_PC])  pick = SEL_PC;
        else if (req[SRC_MDR]) pick = SEL_MDR;
      end
      default: begin
        if (req[SRC_PC])       pick = SEL_PC;
        else if (req[SRC_MDR]) pick = SEL_MDR;
        else if (req[SRC_MAR]) pick = SEL_MAR;
      end
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/out_bus_sequencer_if.sv
// Bundle of source requests, Arduino handshake and status signals around the
// out_bus sequencer; 'slave' is the sequencer side, 'master' the core side.
interface out_bus_sequencer_if;

  logic [2:0]  req;
  logic [15:0] pc_word;
  logic [15:0] mdr_word;
  logic [15:0] mar_word;
  logic        ard_receive_ready;
  logic        clr_error;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic [7:0]  out_bus;
  logic        out_valid;
  logic        busy;
  logic        error;

  modport slave (
    input  req, pc_word, mdr_word, mar_word, ard_receive_ready, clr_error,
    output grant, done, out_bus, out_valid, busy, error
  );

  modport master (
    output req, pc_word, mdr_word, mar_word, ard_receive_ready, clr_error,
    input  grant, done, out_bus, out_valid, busy, error
  );

endinterface

// File: rtl/out_bus_sequencer_sync_edge_detect.sv
// Two-flop synchronizer followed by a registered rising-edge pulse; an input
// held high produces exactly one pulse, three clocks after it rises.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic sync_1;
  logic sync_2;
  logic sync_2_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1      <= 1'b0;
      sync_2      <= 1'b0;
      sync_2_prev <= 1'b0;
      pulse       <= 1'b0;
    end else begin
      sync_1      <= async_in;
      sync_2      <= sync_1;
      sync_2_prev <= sync_2;
      pulse       <= sync_2 & ~sync_2_prev;
    end
  end

endmodule

// File: rtl/out_bus_sequencer.sv
// Round-robin arbiter for PC/MDR/MAR onto the 8-bit Arduino out_bus; each granted
// word goes out as two bytes under the ard_receive_ready edge handshake.
module out_bus_sequencer
  import out_bus_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          LSB_FIRST      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  out_bus_sequencer_if.slave    bus
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  seq_state_t  state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic [2:0]  last_q, last_d;
  logic [15:0] hold_q, hold_d;
  logic [7:0]  out_bus_q, out_bus_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic [2:0]  done_q, done_d;
  logic        error_q, error_d;
  logic [7:0]  timer_q, timer_d;

  logic        accept;
  logic [2:0]  pick;
  logic [15:0] picked_word;
  logic        timed_out;
  logic [7:0]  timer_inc;

  function automatic logic [7:0] first_byte(input logic [15:0] w);
    return LSB_FIRST ? w[7:0] : w[15:8];
  endfunction

  function automatic logic [7:0] second_byte(input logic [15:0] w);
    return LSB_FIRST ? w[15:8] : w[7:0];
  endfunction

  sync_edge_detect u_accept_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (bus.ard_receive_ready),
    .pulse    (accept)
  );

  always_comb begin
    pick        = rr_pick(bus.req, last_q);
    picked_word = bus.mar_word;
    if (pick[SRC_PC])       picked_word = bus.pc_word;
    else if (pick[SRC_MDR]) picked_word = bus.mdr_word;
    timed_out   = (timer_q == TIMEOUT_LAST);
    timer_inc   = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
  end

  // Next-state and next-output logic; every output is the registered value of
  // what the upcoming state presents, so nothing leaks combinationally to a port.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    hold_d      = hold_q;
    out_bus_d   = out_bus_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 3'b000;
    timer_d     = timer_q;
    error_d     = error_q & ~bus.clr_error;

    case (state_q)
      IDLE: begin
        timer_d = 8'd0;
        if (bus.req != 3'b000) begin
          state_d     = BYTE0;
          grant_d     = pick;
          last_d      = pick;
          hold_d      = picked_word;
          out_bus_d   = first_byte(picked_word);
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
        end
      end

      BYTE0, BYTE1: begin
        if (accept) begin
          timer_d = 8'd0;
          if (state_q == BYTE0) begin
            state_d   = BYTE1;
            out_bus_d = second_byte(hold_q);
          end else begin
            state_d = DONE;
            done_d  = grant_q;
          end
        end else if (timed_out) begin
          // Timeout set has priority over a simultaneous clr_error.
          state_d     = ABORT;
          timer_d     = 8'd0;
          grant_d     = 3'b000;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          error_d     = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end

      DONE: begin
        state_d     = IDLE;
        timer_d     = 8'd0;
        grant_d     = 3'b000;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end

      ABORT: begin
        state_d = IDLE;
        timer_d = 8'd0;
      end

      default: begin
        state_d     = IDLE;
        timer_d     = 8'd0;
        grant_d     = 3'b000;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= 3'b000;
      last_q      <= LAST_RESET;
      hold_q      <= 16'h0000;
      out_bus_q   <= 8'h00;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 3'b000;
      error_q     <= 1'b0;
      timer_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      out_bus_q   <= out_bus_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      timer_q     <= timer_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.out_bus   = out_bus_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.error     = error_q;

  grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
  done_onehot:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(done_q));
  last_onehot:  assert property (@(posedge clk) disable iff (!rst_n) $onehot(last_q));
  valid_owned:  assert property (@(posedge clk) disable iff (!rst_n) out_valid_q |-> (grant_q != 3'b000));

endmodule

// File: doc/out_bus_sequencer.md
# out_bus_sequencer

Sequencer and arbiter for the shared 8-bit `out_bus` from the CPU core to the Arduino. Three 16-bit sources (PC, MDR, MAR) request transfers. The block grants one source at a time using round-robin priority and captures its word. It then sends the word as two bytes under an edge-based `ard_receive_ready` handshake, with timeout and error reporting. It replaces the ad-hoc `bus_pc/bus_mdr/bus_mar` one-hot mux select driven by the control FSM.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles allowed per byte without an accept before abort; 8-bit counter, legal range 1..255.
- `LSB_FIRST`, default 1: 1 sends bits [7:0] first then [15:8]; 0 sends the reverse.
- `clk`  in  1  single clock (the `ard_clk` domain in the core).
- `rst`  in  1  reset, asynchronous, active-low.
- `req`  in  3  level requests; bit0 PC, bit1 MDR, bit2 MAR (same order as the core's bus select).
- `pc_word`  in  16  PC source word.
- `mdr_word`  in  16  MDR source word.
- `mar_word`  in  16  MAR source word.
- `ard_receive_ready`  in  1  Arduino accept strobe; asynchronous to `clk`; a rising edge accepts the current byte.
- `clr_error`  in  1  synchronous clear of `error`.
- `grant`  out  3  one-hot owner of the bus, same bit order as `req`.
- `done`  out  3  one-cycle one-hot pulse when a source's second byte is accepted.
- `out_bus`  out  8  byte being presented.
- `out_valid`  out  1  `out_bus` holds a byte awaiting accept.
- `busy`  out  1  a transfer is in progress.
- `error`  out  1  sticky timeout flag.

## Operation
- Reset values:
  - `grant`=0, `done`=0, `out_bus`=0, `out_valid`=0, `busy`=0, `error`=0.
  - FSM = IDLE, timeout counter = 0, synchronizer flops = 0.
  - Round-robin pointer `last` = MAR (3'b100), so PC has first priority after reset.
- `ard_receive_ready` passes through a 2-flop synchronizer and a rising-edge detector, producing `accept`. A level held high accepts exactly one byte.
- States:
  - IDLE: if `req`≠0, choose the first set bit searching upward from `last`+1 (wrapping). Register that one-hot into `grant` and `last`. Capture the selected word into the 16-bit `hold` register. Go to BYTE0. If `req`=0, stay in IDLE.
  - BYTE0: `out_bus` = first byte of `hold`, `out_valid`=1. On `accept`, go to BYTE1 and clear the timer.
  - BYTE1: `out_bus` = second byte, `out_valid`=1. On `accept`, go to DONE.
  - DONE: `done`=`grant` for one cycle. `grant`, `out_valid` and `busy` drop at the end of the cycle. Return to IDLE.
  - ABORT: entered from BYTE0/BYTE1 when the timer reaches `TIMEOUT_CYCLES` without `accept`. Set `error`, clear `grant` and `out_valid`, give no `done` pulse, return to IDLE. The pointer keeps the aborted source as `last`.
- `busy` = 1 in BYTE0, BYTE1 and DONE.
- Timer: increments every BYTE cycle with no `accept` and resets on any state change. It saturates; it never wraps.
- A source dropping `req` mid-transfer does not cancel the transfer: the captured word completes and `done` still pulses.
- Source word changes after capture are ignored.
- `req` bits for the currently granted source are not re-sampled until IDLE.
- `accept` in IDLE or DONE is ignored and not remembered.
- `clr_error` clears `error` in any state. If `clr_error` and a new timeout occur in the same cycle, the set wins.
- Reset asserted mid-transfer forces all reset values immediately; the partial transfer is lost.

## Timing
- `req` sampled in IDLE at cycle N: `grant` and `out_valid` are high with byte0 from cycle N+1 (registered outputs).
- Accept latency: a rising edge of `ard_receive_ready` at the input becomes `accept` 3 cycles later (2 sync flops + edge register).
- The next byte appears on the cycle after `accept`.
- `done` pulses on the cycle after the byte1 `accept`.
- Minimum of one IDLE cycle between consecutive grants. Back-to-back transfers use at most 3+3 handshake cycles plus 3 overhead cycles.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- Add to the shared types package (`types.vh`):
  - `seq_state_t` enum {IDLE, BYTE0, BYTE1, DONE, ABORT}.
  - Source index constants SRC_PC=0, SRC_MDR=1, SRC_MAR=2.
- One sub-module: `sync_edge_detect` (2-flop synchronizer plus rising-edge pulse, async active-low reset). It is reusable for `ard_data_ready`.
- Arbitration, timer and FSM live in the top module.

## Test plan
- Reset, then `req`=3'b001 with `pc_word`=16'hA55A, and two `ard_receive_ready` pulses → `out_bus` shows 8'h5A then 8'hA5; `done`=3'b001 for 1 cycle; `grant` returns to 0.
- `req`=3'b111 held with words PC=16'h1111, MDR=16'h2222, MAR=16'h3333 → grants in order PC, MDR, MAR, PC; each `done` one-hot matches its grant.
- `ard_receive_ready` held high for 10 cycles during BYTE0 → only byte0 is accepted; the FSM waits in BYTE1 with `out_bus`=second byte.
- No accept for `TIMEOUT_CYCLES`=4 → ABORT after 4 BYTE0 cycles; `error`=1, no `done`; `clr_error` clears it; the next `req` is served normally.
- `mdr_word` changed and `req[1]` dropped after the grant → the original captured bytes are sent and `done`=3'b010 still pulses.
- Reset asserted during BYTE1 → all outputs are 0 in the same cycle; after release, `req`=3'b100 is granted MAR first.
